operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Register-read stage: the reading side of the 16x8 register file that the writeback stage updates.
- Latches an issued instruction and reads its source operands from the packed register view.
- Tracks in-flight destination writes in a 16-bit scoreboard and stalls on read-after-write hazards.
- Bypasses a value being written back in the same cycle, then hands op, destination and operands to execute with a one-cycle ready pulse.

Parameters:
OP_LOD, 4'b0001, load opcode; writes rd, reads rs (address)
OP_STO, 4'b0010, store opcode; reads rd (data) and rs (address), no writeback
OP_ADD, 4'b0011, add; writes rd, reads rd and rs
OP_ADDI, 4'b0100, add immediate; writes rd, reads rd, b = imm
OP_LODI, 4'b0101, load immediate; writes rd, b = imm
OP_NAND, 4'b0110, nand; writes rd, reads rd and rs

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  synchronous, active-high reset
en  input  1  issue strobe; sampled only in IDLE
op  input  4  opcode to fetch
rd_addr  input  4  destination / first source register
rs_addr  input  4  second source register
imm  input  8  immediate
regs  input  128  packed register file, reg i = regs[8*i +: 8]
wb_en  input  1  writeback stage active this cycle
wb_op  input  4  opcode in writeback
wb_reg_addr  input  4  writeback destination
wb_val  input  8  writeback value
op_out  output  4  latched opcode
dst_out  output  4  latched rd_addr
a_val  output  8  operand A
b_val  output  8  operand B
ready  output  1  one-cycle pulse: outputs valid
stalled  output  1  high while FETCH is blocked by a hazard

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst). rst has priority over all other activity.
- Reset values: state=IDLE, scoreboard=0, ready=0, stalled=0, op_out=0, dst_out=0, a_val=0, b_val=0.
- Decode functions:
  - uses_a = op in {ADD, ADDI, NAND, STO}
  - uses_b = op in {ADD, NAND, LOD, STO}
  - writes = op in {LOD, ADD, ADDI, LODI, NAND}
  - Unknown opcodes use nothing and write nothing.
- IDLE: en=1 latches op, rd_addr, rs_addr and imm, then goes to FETCH. ready is 0 in every cycle except the pulse cycle.
- FETCH:
  - Hazard = (uses_a and pend[rd] and not wb_hit(rd)) or (uses_b and pend[rs] and not wb_hit(rs)).
  - wb_hit(r) = wb_en and writes(wb_op) and wb_reg_addr==r.
  - Hazard: stay in FETCH with stalled=1.
  - No hazard: register the outputs. a_val = wb_hit(rd) ? wb_val : regs[rd]. b_val = imm for ADDI/LODI, otherwise wb_hit(rs) ? wb_val : regs[rs]. Unused operands are 0. Set ready=1 and stalled=0 next cycle, and return to IDLE.
- Latency: en in cycle N, ready high in cycle N+2 with no hazard. Each stall cycle adds 1.
- en is ignored outside IDLE. The upstream stage holds the instruction until ready.
- Scoreboard:
  - Clear: on wb_en and writes(wb_op), clear pend[wb_reg_addr].
  - Set: on FETCH completion with writes(op), set pend[rd].
  - Same bit cleared and set in the same cycle: set wins.
- Reset mid-FETCH or mid-stall: the instruction is dropped, the scoreboard is cleared, and ready is not pulsed.
- r0 has no special meaning; all 16 registers are treated alike.

Decomposition:
- Shared package: opcode localparams, register count (16), data width (8), and the writes() function. writeback and operand_fetch must decode writeback ops identically.
- No sub-module is needed. The 16-bit scoreboard may be written as an inline always block.

Test Plan:
- Reset held 2 cycles -> ready=0, stalled=0, a_val=b_val=0. en during reset has no effect after release.
- regs r1=0x05, r2=0x0A; ADD rd=1 rs=2 en in cycle N -> ready pulse in N+2 only, a=0x05, b=0x0A, op_out=ADD, dst_out=1, pend[1]=1.
- ADDI rd=3 imm=0x7F -> b=0x7F, a=regs[3]. Then ADD rd=4 rs=3 -> stalled=1. Drive wb_en=1, wb_op=ADDI, wb_reg_addr=3, wb_val=0x22 while regs[3] is still stale -> next cycle ready=1, b=0x22, pend[3]=0.
- STO rd=6 rs=7 -> ready pulse, pend stays 0. Then wb_en with wb_op=STO, wb_reg_addr=6 -> no scoreboard change.
- pend[5]=1, then ADD rd=5 rs=5 completes while wb clears r5 in the same cycle -> pend[5] remains 1.
- Stall on pend[2], then assert rst for 1 cycle -> IDLE, scoreboard=0, no ready pulse. A fresh ADD rd=2 then completes in 2 cycles.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared decode for the register-read stage and the writeback stage.
// Both stages must agree on which opcodes write a destination register,
// so writes() lives here and nowhere else.
package operand_fetch_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned REGS_W   = NUM_REGS * DATA_W;

    localparam logic [OP_W-1:0] OP_LOD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_STO  = 4'b0010;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0011;
    localparam logic [OP_W-1:0] OP_ADDI = 4'b0100;
    localparam logic [OP_W-1:0] OP_LODI = 4'b0101;
    localparam logic [OP_W-1:0] OP_NAND = 4'b0110;

    // Opcode produces a value for its rd register.
    function automatic logic writes(input logic [OP_W-1:0] op);
        case (op)
            OP_LOD, OP_ADD, OP_ADDI, OP_LODI, OP_NAND: writes = 1'b1;
            default:                                   writes = 1'b0;
        endcase
    endfunction

    // Operand A is read from rd.
    function automatic logic uses_a(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_NAND, OP_STO: uses_a = 1'b1;
            default:                          uses_a = 1'b0;
        endcase
    endfunction

    // Operand B is read from rs.
    function automatic logic uses_b(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_NAND, OP_LOD, OP_STO: uses_b = 1'b1;
            default:                         uses_b = 1'b0;
        endcase
    endfunction

    // Operand B comes from the immediate field instead of the register file.
    function automatic logic uses_imm(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI, OP_LODI: uses_imm = 1'b1;
            default:          uses_imm = 1'b0;
        endcase
    endfunction

    // Pick register idx out of the packed register view.
    function automatic logic [DATA_W-1:0] reg_at(input logic [REGS_W-1:0] regs,
                                                 input logic [ADDR_W-1:0] idx);
        reg_at = regs[DATA_W*idx +: DATA_W];
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue, register-view, writeback and execute-side signals of the read stage.
// master = the surrounding pipeline, slave = operand_fetch.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    // issue side
    logic              en;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rs_addr;
    logic [DATA_W-1:0] imm;

    // register file view and writeback stage
    logic [REGS_W-1:0] regs;
    logic              wb_en;
    logic [OP_W-1:0]   wb_op;
    logic [ADDR_W-1:0] wb_reg_addr;
    logic [DATA_W-1:0] wb_val;

    // execute side
    logic [OP_W-1:0]   op_out;
    logic [ADDR_W-1:0] dst_out;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic              ready;
    logic              stalled;

    modport master (
        output en, op, rd_addr, rs_addr, imm,
        output regs, wb_en, wb_op, wb_reg_addr, wb_val,
        input  op_out, dst_out, a_val, b_val, ready, stalled
    );

    modport slave (
        input  en, op, rd_addr, rs_addr, imm,
        input  regs, wb_en, wb_op, wb_reg_addr, wb_val,
        output op_out, dst_out, a_val, b_val, ready, stalled
    );

endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: latches an issued instruction, waits out read-after-write
// hazards against a pending-write scoreboard, bypasses a same-cycle writeback
// and presents op/dst/operands to execute with a one-cycle ready pulse.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input logic            clk,
    input logic            rst,
    operand_fetch_if.slave bus
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StFetch = 1'b1;

    logic [0:0]          state_q, state_d;

    // latched instruction
    logic [OP_W-1:0]     op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [ADDR_W-1:0]   rs_q;
    logic [DATA_W-1:0]   imm_q;

    // one bit per register with a write still in flight
    logic [NUM_REGS-1:0] pend_q, pend_d;

    // execute-facing outputs
    logic [OP_W-1:0]     op_out_q;
    logic [ADDR_W-1:0]   dst_out_q;
    logic [DATA_W-1:0]   a_val_q;
    logic [DATA_W-1:0]   b_val_q;
    logic                ready_q;
    logic                stalled_q;

    logic                issue;
    logic                wb_writes;
    logic                wb_hit_a;
    logic                wb_hit_b;
    logic                hazard;
    logic                fetch_done;
    logic [DATA_W-1:0]   a_next;
    logic [DATA_W-1:0]   b_next;

    // Writeback visibility and hazard detection for the latched instruction.
    always_comb begin
        issue      = (state_q == StIdle) && bus.en;
        wb_writes  = bus.wb_en && writes(bus.wb_op);
        wb_hit_a   = wb_writes && (bus.wb_reg_addr == rd_q);
        wb_hit_b   = wb_writes && (bus.wb_reg_addr == rs_q);
        // A pending source being written back this very cycle is not a hazard:
        // the bypass below supplies the value.
        hazard     = (uses_a(op_q) && pend_q[rd_q] && !wb_hit_a) ||
                     (uses_b(op_q) && pend_q[rs_q] && !wb_hit_b);
        fetch_done = (state_q == StFetch) && !hazard;
    end

    // Operand selection with same-cycle writeback bypass; unused operands are 0.
    always_comb begin
        a_next = '0;
        b_next = '0;
        if (uses_a(op_q)) begin
            a_next = wb_hit_a ? bus.wb_val : reg_at(bus.regs, rd_q);
        end
        if (uses_imm(op_q)) begin
            b_next = imm_q;
        end else if (uses_b(op_q)) begin
            b_next = wb_hit_b ? bus.wb_val : reg_at(bus.regs, rs_q);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.en) state_d = StFetch;
            StFetch: if (!hazard) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Scoreboard update; the set is applied last so it wins over a clear of the same bit.
    always_comb begin
        pend_d = pend_q;
        if (wb_writes) begin
            pend_d[bus.wb_reg_addr] = 1'b0;
        end
        if (fetch_done && writes(op_q)) begin
            pend_d[rd_q] = 1'b1;
        end
    end

    // FSM state and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Instruction latch, loaded only when an issue is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs_q  <= '0;
            imm_q <= '0;
        end else if (issue) begin
            op_q  <= bus.op;
            rd_q  <= bus.rd_addr;
            rs_q  <= bus.rs_addr;
            imm_q <= bus.imm;
        end
    end

    // Execute-facing outputs: data held between fetches, ready is a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_out_q  <= '0;
            dst_out_q <= '0;
            a_val_q   <= '0;
            b_val_q   <= '0;
            ready_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            ready_q   <= fetch_done;
            stalled_q <= (state_q == StFetch) && hazard;
            if (fetch_done) begin
                op_out_q  <= op_q;
                dst_out_q <= rd_q;
                a_val_q   <= a_next;
                b_val_q   <= b_next;
            end
        end
    end

    assign bus.op_out  = op_out_q;
    assign bus.dst_out = dst_out_q;
    assign bus.a_val   = a_val_q;
    assign bus.b_val   = b_val_q;
    assign bus.ready   = ready_q;
    assign bus.stalled = stalled_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random instructions
// with random writeback traffic, checked against a transaction-level model.
module tb_operand_fetch;

    localparam logic [3:0] LOD  = 4'd1;
    localparam logic [3:0] STO  = 4'd2;
    localparam logic [3:0] ADD  = 4'd3;
    localparam logic [3:0] ADDI = 4'd4;
    localparam logic [3:0] LODI = 4'd5;
    localparam logic [3:0] NAND = 4'd6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_if bus ();
    operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] rf [16];
    always_comb begin
        for (int i = 0; i < 16; i++) bus.regs[8*i +: 8] = rf[i];
    end

    int compared   = 0;
    int mismatched = 0;

    function automatic logic m_writes(input logic [3:0] op);
        return op inside {LOD, ADD, ADDI, LODI, NAND};
    endfunction
    function automatic logic m_uses_a(input logic [3:0] op);
        return op inside {ADD, ADDI, NAND, STO};
    endfunction
    function automatic logic m_uses_b(input logic [3:0] op);
        return op inside {ADD, NAND, LOD, STO};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_idle();
        bus.wb_en = 1'b0; bus.wb_op = 4'd0; bus.wb_reg_addr = 4'd0; bus.wb_val = 8'd0;
    endtask

    task automatic wb_drive(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] val);
        bus.wb_en = 1'b1; bus.wb_op = op; bus.wb_reg_addr = addr; bus.wb_val = val;
    endtask

    // Present an instruction for one cycle; returns in the first FETCH cycle.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [7:0] imm);
        bus.en = 1'b1; bus.op = op; bus.rd_addr = rd; bus.rs_addr = rs; bus.imm = imm;
        tick();
        bus.en = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [3:0] op, input logic [3:0] dst,
                              input logic [7:0] a, input logic [7:0] b, input logic [15:0] pend);
        check({tag, "_ready"}, bus.ready, 1);
        check({tag, "_stalled"}, bus.stalled, 0);
        check({tag, "_op"}, bus.op_out, op);
        check({tag, "_dst"}, bus.dst_out, dst);
        check({tag, "_a"}, bus.a_val, a);
        check({tag, "_b"}, bus.b_val, b);
        check({tag, "_pend"}, dut.pend_q, pend);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m_pend;
        logic [3:0]  op, rd, rs;
        logic [7:0]  imm, ea, eb;
        logic        hit_a, hit_b, hz, done;

        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        rf[1] = 8'h05; rf[2] = 8'h0A; rf[3] = 8'h11; rf[4] = 8'h33;
        rf[5] = 8'h50; rf[6] = 8'h66; rf[7] = 8'h77;
        wb_idle();

        // Reset held two cycles with an issue attempt that must be ignored.
        rst = 1'b1;
        bus.en = 1'b1; bus.op = ADD; bus.rd_addr = 4'd1; bus.rs_addr = 4'd2; bus.imm = 8'h00;
        tick(); tick();
        check("rst_ready", bus.ready, 0);
        check("rst_stalled", bus.stalled, 0);
        check("rst_a", bus.a_val, 0);
        check("rst_b", bus.b_val, 0);
        check("rst_op", bus.op_out, 0);
        check("rst_dst", bus.dst_out, 0);
        check("rst_pend", dut.pend_q, 0);
        rst = 1'b0; bus.en = 1'b0;
        tick(); tick();
        check("post_rst_ready", bus.ready, 0);
        check("post_rst_pend", dut.pend_q, 0);

        // ADD r1,r2: ready exactly in N+2.
        issue(ADD, 4'd1, 4'd2, 8'h00);
        check("add_n1_ready", bus.ready, 0);
        tick();
        check_done("add", ADD, 4'd1, 8'h05, 8'h0A, 16'h0002);
        tick();
        check("add_n3_ready", bus.ready, 0);

        // ADDI r3 takes the immediate as B.
        issue(ADDI, 4'd3, 4'd0, 8'h7F);
        tick();
        check_done("addi", ADDI, 4'd3, 8'h11, 8'h7F, 16'h000A);

        // ADD r4,r3 stalls on r3; en during the stall is ignored; wb bypass releases it.
        issue(ADD, 4'd4, 4'd3, 8'h00);
        tick();
        check("raw_stalled1", bus.stalled, 1);
        check("raw_ready1", bus.ready, 0);
        bus.en = 1'b1; bus.op = NAND; bus.rd_addr = 4'd9; bus.rs_addr = 4'd9;
        tick();
        check("raw_stalled2", bus.stalled, 1);
        check("raw_ready2", bus.ready, 0);
        bus.en = 1'b0;
        wb_drive(ADDI, 4'd3, 8'h22);
        tick();
        wb_idle();
        check_done("raw_bypass", ADD, 4'd4, 8'h33, 8'h22, 16'h0012);
        tick();
        check("raw_after_ready", bus.ready, 0);

        // STO writes nothing; a STO in writeback does not clear.
        issue(STO, 4'd6, 4'd7, 8'h00);
        tick();
        check_done("sto", STO, 4'd6, 8'h66, 8'h77, 16'h0012);
        wb_drive(STO, 4'd1, 8'hEE);
        tick();
        check("sto_wb_no_clear", dut.pend_q, 16'h0012);
        wb_drive(STO, 4'd6, 8'hEE);
        tick();
        check("sto_wb_r6", dut.pend_q, 16'h0012);
        wb_drive(LOD, 4'd1, 8'hEE);
        tick();
        wb_idle();
        check("lod_wb_clear", dut.pend_q, 16'h0010);

        // Same-cycle clear and set of r5: set wins.
        issue(LODI, 4'd5, 4'd0, 8'h55);
        tick();
        check_done("lodi", LODI, 4'd5, 8'h00, 8'h55, 16'h0030);
        issue(ADD, 4'd5, 4'd5, 8'h00);
        wb_drive(LODI, 4'd5, 8'h99);
        tick();
        wb_idle();
        check_done("set_wins", ADD, 4'd5, 8'h99, 8'h99, 16'h0030);

        // Unknown opcode reads nothing and writes nothing.
        issue(4'hF, 4'd7, 4'd8, 8'hAB);
        tick();
        check_done("unknown", 4'hF, 4'd7, 8'h00, 8'h00, 16'h0030);

        // Reset during a stall drops the instruction and clears the scoreboard.
        issue(LODI, 4'd2, 4'd0, 8'h02);
        tick();
        check("lodi2_pend", dut.pend_q, 16'h0034);
        issue(ADD, 4'd2, 4'd2, 8'h00);
        tick();
        check("pre_rst_stalled", bus.stalled, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", bus.ready, 0);
        check("mid_rst_stalled", bus.stalled, 0);
        check("mid_rst_pend", dut.pend_q, 0);
        tick();
        check("after_rst_ready", bus.ready, 0);
        issue(ADD, 4'd2, 4'd2, 8'h00);
        tick();
        check_done("fresh_add", ADD, 4'd2, 8'h0A, 8'h0A, 16'h0004);
        m_pend = 16'h0004;

        // Random instructions against random writeback traffic.
        for (int it = 0; it < 150; it++) begin
            for (int r = 0; r < 16; r++) rf[r] = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                m_pend = '0;
                check("rnd_rst_pend", dut.pend_q, 0);
            end
            op  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 6));
            rd  = 4'($urandom);
            rs  = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom);
            imm = 8'($urandom);

            // issue cycle, possibly with a writeback in flight
            if ($urandom_range(0, 1) == 1)
                wb_drive(4'($urandom), 4'($urandom), 8'($urandom));
            if (bus.wb_en && m_writes(bus.wb_op)) m_pend[bus.wb_reg_addr] = 1'b0;
            issue(op, rd, rs, imm);
            check("rnd_issue_ready", bus.ready, 0);
            check("rnd_issue_pend", dut.pend_q, m_pend);

            done = 1'b0;
            for (int cyc = 0; cyc < 40 && !done; cyc++) begin
                if (cyc >= 8) begin
                    // guarantee progress by retiring a blocking write
                    wb_drive(LOD, (m_uses_a(op) && m_pend[rd]) ? rd : rs, 8'($urandom));
                end else if ($urandom_range(0, 2) == 0) begin
                    wb_drive(4'($urandom_range(0, 7)),
                             ($urandom_range(0, 1) == 1) ? rs : 4'($urandom), 8'($urandom));
                end else begin
                    wb_idle();
                end
                hit_a = bus.wb_en && m_writes(bus.wb_op) && bus.wb_reg_addr == rd;
                hit_b = bus.wb_en && m_writes(bus.wb_op) && bus.wb_reg_addr == rs;
                hz = (m_uses_a(op) && m_pend[rd] && !hit_a) || (m_uses_b(op) && m_pend[rs] && !hit_b);
                ea = m_uses_a(op) ? (hit_a ? bus.wb_val : rf[rd]) : 8'h00;
                if (op == ADDI || op == LODI) eb = imm;
                else eb = m_uses_b(op) ? (hit_b ? bus.wb_val : rf[rs]) : 8'h00;
                if (bus.wb_en && m_writes(bus.wb_op)) m_pend[bus.wb_reg_addr] = 1'b0;
                if (!hz && m_writes(op)) m_pend[rd] = 1'b1;
                tick();
                if (hz) begin
                    check("rnd_stall_stalled", bus.stalled, 1);
                    check("rnd_stall_ready", bus.ready, 0);
                    check("rnd_stall_pend", dut.pend_q, m_pend);
                end else begin
                    check_done("rnd", op, rd, ea, eb, m_pend);
                    done = 1'b1;
                end
            end
            if (!done) check("rnd_timeout", 0, 1);
            wb_idle();
            tick();
            check("rnd_pulse_end", bus.ready, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
